// File: rtl/mmio_timer_slave_if.sv
// Memory-map bus seen by the timer: shared write data/address, write and select
// strobes from the decoder, and the combinational read-data return path.
interface mmio_timer_slave_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] address;
  logic                  we;
  logic                  re;
  logic [DATA_WIDTH-1:0] rd;

  modport master (
    output wd, address, we, re,
    input  rd
  );

  modport slave (
    input  wd, address, we, re,
    output rd
  );
endinterface

// File: rtl/mmio_timer_slave.sv
// Memory-mapped 32-bit down-counting timer with prescaler, one-shot/auto-reload
// modes, sticky W1C expiry flag and a level interrupt.
module mmio_timer_slave #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mmio_timer_slave_if.slave   bus,
  output logic                o_irq
);

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_LOAD   = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;
  localparam logic [1:0] OFS_STATUS = 2'd3;

  logic                  en;
  logic                  auto_rl;
  logic                  ie;
  logic [7:0]            prescale;
  logic [7:0]            pcnt;
  logic [DATA_WIDTH-1:0] load;
  logic [DATA_WIDTH-1:0] count;
  logic                  expired;

  logic       wr;
  logic [1:0] sel;
  logic       wr_ctrl;
  logic       wr_load;
  logic       wr_count;
  logic       wr_status;
  logic       tick;
  logic       expire_evt;
  logic       unused_addr;

  assign sel         = bus.address[3:2];
  assign wr          = bus.we & bus.re;
  assign wr_ctrl     = wr && (sel == OFS_CTRL);
  assign wr_load     = wr && (sel == OFS_LOAD);
  assign wr_count    = wr && (sel == OFS_COUNT);
  assign wr_status   = wr && (sel == OFS_STATUS);
  assign unused_addr = ^{bus.address[DATA_WIDTH-1:4], bus.address[1:0]};

  assign tick       = en && (pcnt == prescale);
  assign expire_evt = tick && (count == '0);

  assign o_irq = expired & ie;

  // Bus writes always take precedence over the timer's own updates, except that
  // a fresh expiry outranks a same-edge W1C of the flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
      pcnt     <= '0;
      load     <= '0;
      count    <= '0;
      expired  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en       <= bus.wd[0];
        auto_rl  <= bus.wd[1];
        ie       <= bus.wd[2];
        prescale <= bus.wd[15:8];
      end else if (expire_evt && !auto_rl) begin
        en <= 1'b0;
      end

      if (wr_ctrl || !en || tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 8'd1;
      end

      if (wr_load) begin
        load <= bus.wd;
      end

      // Reload uses the pre-edge LOAD, so a coincident LOAD write applies next time.
      if (wr_count) begin
        count <= bus.wd;
      end else if (tick) begin
        if (count != '0) begin
          count <= count - DATA_WIDTH'(1);
        end else if (auto_rl) begin
          count <= load;
        end
      end

      if (expire_evt) begin
        expired <= 1'b1;
      end else if (wr_status && bus.wd[0]) begin
        expired <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.rd = '0;
    if (bus.re) begin
      case (sel)
        OFS_CTRL:   bus.rd = {{(DATA_WIDTH-16){1'b0}}, prescale, 5'b0, ie, auto_rl, en};
        OFS_LOAD:   bus.rd = load;
        OFS_COUNT:  bus.rd = count;
        OFS_STATUS: bus.rd = {{(DATA_WIDTH-1){1'b0}}, expired};
        default:    bus.rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer_slave.sv
// Directed bench for mmio_timer_slave: stimulus pushes hand-computed read
// results into a scoreboard queue that a negedge monitor drains and compares.
module tb_mmio_timer_slave;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  logic mon_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  mmio_timer_slave_if #(.DATA_WIDTH(32)) bus();

  mmio_timer_slave #(.DATA_WIDTH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave),
    .o_irq (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act_rd, input logic act_irq,
                             input logic [31:0] exp_rd, input logic exp_irq);
    checks++;
    if (act_rd !== exp_rd || act_irq !== exp_irq) begin
      errors++;
      $display("[TB] FAIL %s: got rd=%08h irq=%b, expected rd=%08h irq=%b",
               name, act_rd, act_irq, exp_rd, exp_irq);
    end
  endtask

  // Monitor: whenever the bench marks a cycle as observed, pop and compare
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard: DUT output observed with no expected entry");
        end else begin
          e = exp_q.pop_front();
          checkOutput(e.name, bus.rd, irq, e.rd, e.irq);
        end
      end
    end
  end

  // One bus cycle, ending 1ns after the rising edge
  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] addr,
                               input logic [31:0] data, input logic mon, input string name,
                               input logic [31:0] erd, input logic eirq);
    exp_t e;
    bus.we      = w;
    bus.re      = r;
    bus.address = addr;
    bus.wd      = data;
    mon_valid   = mon;
    if (mon) begin
      e.name = name;
      e.rd   = erd;
      e.irq  = eirq;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    mon_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, addr, data, 1'b0, "", 32'h0, 1'b0);
  endtask

  task automatic do_read(input string name, input logic [31:0] addr,
                         input logic [31:0] erd, input logic eirq);
    applyStimulus(1'b0, 1'b1, addr, 32'h0, 1'b1, name, erd, eirq);
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "", 32'h0, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0, "", 32'h0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    do_read({tag, "_ctrl"},   32'h0, 32'h0, 1'b0);
    do_read({tag, "_load"},   32'h4, 32'h0, 1'b0);
    do_read({tag, "_count"},  32'h8, 32'h0, 1'b0);
    do_read({tag, "_status"}, 32'hC, 32'h0, 1'b0);
  endtask

  initial begin
    bus.we      = 1'b1;
    bus.re      = 1'b1;
    bus.address = 32'h0;
    bus.wd      = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    do_reset();
    read_all_zero("reset");

    // Readback and CTRL field masking, including an aliased address
    do_write(32'h4, 32'h1234_5678);
    do_read("load_rb", 32'h4, 32'h1234_5678, 1'b0);
    do_write(32'h0, 32'hFFFF_FFFF);
    do_read("ctrl_mask", 32'h0, 32'h0000_FF07, 1'b0);
    do_read("ctrl_alias_0x13", 32'h13, 32'h0000_FF07, 1'b0);
    do_write(32'h0, 32'h0);

    // Bus gating
    applyStimulus(1'b1, 1'b0, 32'h4, 32'hDEAD_BEEF, 1'b0, "", 32'h0, 1'b0);
    do_read("we_no_re", 32'h4, 32'h1234_5678, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h4, 32'h0, 1'b1, "rd_zero_no_re", 32'h0, 1'b0);

    // One-shot: COUNT=3, P=0 -> expiry 4 edges after the CTRL write
    do_write(32'h8, 32'd3);
    do_write(32'h0, 32'h05);
    do_read("os_cnt3", 32'h8, 32'd3, 1'b0);
    do_read("os_cnt2", 32'h8, 32'd2, 1'b0);
    do_read("os_cnt1", 32'h8, 32'd1, 1'b0);
    do_read("os_not_yet", 32'hC, 32'd0, 1'b0);
    do_read("os_expired", 32'hC, 32'd1, 1'b1);
    do_read("os_en_clear", 32'h0, 32'h04, 1'b1);
    do_read("os_cnt_hold", 32'h8, 32'd0, 1'b1);
    do_write(32'hC, 32'h0);
    do_read("w0_no_clear", 32'hC, 32'd1, 1'b1);
    do_write(32'hC, 32'h1);
    do_read("w1c_clear", 32'hC, 32'd0, 1'b0);

    // W1C coinciding with expiry: set wins
    do_write(32'h8, 32'd1);
    do_write(32'h0, 32'h05);
    do_idle(1);
    do_write(32'hC, 32'h1);
    do_read("w1c_race", 32'hC, 32'd1, 1'b1);
    do_read("w1c_race_en", 32'h0, 32'h04, 1'b1);
    do_write(32'hC, 32'h1);

    // CTRL write with EN=1 on a one-shot expiry edge keeps EN
    do_write(32'h8, 32'd1);
    do_write(32'h0, 32'h01);
    do_idle(1);
    do_write(32'h0, 32'h01);
    do_read("ctrl_beats_stop", 32'h0, 32'h01, 1'b0);
    do_read("ctrl_beats_stop_st", 32'hC, 32'd1, 1'b0);
    do_read("ctrl_then_stop", 32'h0, 32'h00, 1'b0);
    do_write(32'hC, 32'h1);

    // COUNT write on a tick edge wins over the decrement
    do_write(32'h8, 32'd50);
    do_write(32'h0, 32'h01);
    do_write(32'h8, 32'd100);
    do_read("cnt_write_wins", 32'h8, 32'd100, 1'b0);
    do_write(32'h0, 32'h00);
    do_read("cnt_dec", 32'h8, 32'd98, 1'b0);

    // Prescaled auto-reload: LOAD=2, P=3 -> expiry every 12 cycles
    do_write(32'h4, 32'd2);
    do_write(32'h8, 32'd2);
    do_write(32'h0, 32'h0303);
    do_idle(3);
    do_read("ar_cnt2", 32'h8, 32'd2, 1'b0);
    do_read("ar_cnt1", 32'h8, 32'd1, 1'b0);
    do_idle(2);
    do_read("ar_st_e7", 32'hC, 32'd0, 1'b0);
    do_read("ar_cnt0", 32'h8, 32'd0, 1'b0);
    do_idle(2);
    do_read("ar_st_e11", 32'hC, 32'd0, 1'b0);
    do_read("ar_st_e12", 32'hC, 32'd1, 1'b0);
    do_read("ar_reload", 32'h8, 32'd2, 1'b0);
    do_write(32'hC, 32'h1);
    do_idle(7);
    do_read("ar2_st_e22", 32'hC, 32'd0, 1'b0);
    do_read("ar2_st_e23", 32'hC, 32'd0, 1'b0);
    do_read("ar2_st_e24", 32'hC, 32'd1, 1'b0);

    // Reset mid-count with irq asserted and a concurrent write
    do_write(32'h0, 32'h0307);
    do_read("pre_reset_irq", 32'hC, 32'd1, 1'b1);
    do_reset();
    read_all_zero("midreset");

    do_idle(2);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_timer_slave.md
# mmio_timer_slave

Memory-mapped 32-bit down-counting timer; a responder on the core's data memory-map bus, alongside the RAM and UART slaves. The memory map decodes the timer's base address and drives write/select strobes, shared write data and address. The timer returns read data combinationally, so it fits the MEM→WB pipeline register like the other slaves. It provides a prescaled countdown, one-shot or auto-reload modes, a sticky expiry flag and a level interrupt.

## Interface
- DATA_WIDTH, 32, bus data width; only 32 is supported.
- i_clk  input  1  single clock; all state changes on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- wd  input  32  write data from the memory map.
- address  input  32  byte address from the memory map; only bits [3:2] are decoded; bits [1:0] and above [3] are ignored.
- we  input  1  write strobe (WSel from the memory map).
- re  input  1  select/read strobe (HSel from the memory map).
- rd  output  32  read data, combinational; 0 when re=0.
- o_irq  output  1  interrupt, equal to STATUS.EXPIRED & CTRL.IE.

## Operation
- Register map, selected by word offset address[3:2]:
  - 0x0 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE, bits[15:8] PRESCALE. Other bits are read as 0 and ignored on write.
  - 0x4 LOAD: 32-bit reload value.
  - 0x8 COUNT: current count. A write loads the count directly.
  - 0xC STATUS: bit0 EXPIRED, sticky. Writing 1 to bit0 clears it; writing 0 has no effect.
- Prescaler:
  - Internal 8-bit pcnt.
  - tick = EN & (pcnt == PRESCALE).
  - While EN=1, pcnt increments each cycle and wraps to 0 on tick.
  - While EN=0, pcnt holds at 0.
  - A CTRL write that sets EN forces pcnt to 0.
- Count behaviour on tick:
  - If COUNT != 0: COUNT <= COUNT - 1.
  - If COUNT == 0: EXPIRED <= 1. Then, if AUTO=1, COUNT <= LOAD; if AUTO=0, EN <= 0 (one-shot stop) and COUNT stays 0.
- Reads have no side effects. rd = re ? selected register : 0.
- Writes occur when we=1 and re=1. A write with we=1 and re=0 is ignored.

## Timing
- Reset: CTRL, LOAD, COUNT, STATUS and pcnt all 0. Outputs after reset: rd=0, o_irq=0.
- Writes take effect at the edge where we&re=1. A read in the following cycle returns the new value.
- Tick decisions use register values from before the edge.
- Simultaneous events, priority rules:
  - A COUNT write beats a decrement or reload in the same cycle.
  - A CTRL write beats the one-shot EN clear.
  - When a set and a W1C clear of EXPIRED coincide, the set wins and EXPIRED stays 1.
  - A LOAD write coinciding with a reload: COUNT takes the old LOAD; the new LOAD applies from the next reload.
- Expiry latency: take edge E as the one that writes EN=1, with starting COUNT=N and PRESCALE=P. EXPIRED becomes 1 after edge E + (N+1)(P+1).
- Auto-reload period: (LOAD+1)(P+1) cycles between EXPIRED events.
- o_irq follows its registered sources in the same cycle; no added delay.
- Count wrap-around: COUNT never underflows; 0 is the expiry point. COUNT=0xFFFFFFFF is legal and decrements normally.
- Reset mid-count: the next edge with i_rst=1 clears all state regardless of concurrent we. o_irq deasserts in the same cycle as that clearing edge.

## Test plan
- Reset/readback:
  - Assert i_rst with we=re=1 -> every register reads 0 and o_irq=0.
  - Write LOAD=0x12345678 -> reads 0x12345678.
  - Write CTRL=0xFFFFFFFF -> reads 0x0000FF07.
- One-shot:
  - COUNT=3, CTRL=0x05 (EN, IE, P=0) -> EXPIRED=1 and o_irq=1 exactly 4 edges after the CTRL write.
  - Afterwards CTRL.EN reads 0 and COUNT stays 0.
- Prescaled auto-reload:
  - LOAD=2, COUNT=2, CTRL=0x0303 (EN, AUTO, P=3) -> first EXPIRED set at 12 cycles.
  - Clear via STATUS=1, then next set at 12 cycles later; COUNT sequence 2,1,0,2.
- W1C race:
  - Write STATUS=1 on the same edge as an expiry -> EXPIRED remains 1.
  - Writing STATUS=0 never clears EXPIRED.
- Write priority:
  - Write COUNT=100 on a tick edge -> reads 100, not 99.
  - Write CTRL EN=1 on a one-shot expiry edge -> EN stays 1.
- Bus gating:
  - we=1, re=0 -> no register changes.
  - re=0 -> rd=0.
  - address 0x13 decodes as offset 0x0 (CTRL).
